// File: rtl/if_id_skid_reg_pkg.sv
// Shared definitions for the IF->ID skid pipeline register.
//   skid_state_e      : occupancy of the two-entry buffer (EMPTY/ONE/FULL)
//   NOP_INST_DEFAULT  : instruction shown to decode when nothing valid is held
//   EXTRA_PRED/FAULT  : bit positions inside the fetch sideband field
package if_id_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    localparam int EXTRA_PRED  = 0;
    localparam int EXTRA_FAULT = 1;

endpackage

// File: rtl/if_id_skid_reg_skid_buf.sv
// pipe_skid_buf: generic two-entry skid buffer.
//   clk, rst         : clock, synchronous active-high reset
//   flush            : drop every held entry, go EMPTY
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake (out_data is the main register)
//   empty_data       : value loaded into the main register whenever it empties
//   state            : current occupancy, exposed for observation
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready and out_valid are decoded from the state register alone, so
// neither depends combinationally on in_valid or out_ready.
module pipe_skid_buf
    import if_id_skid_reg_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic [DATA_W-1:0] empty_data,
    output skid_state_e       state
);

    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= RST_DATA;
            skid_q <= '0;
        end else if (flush) begin
            // A concurrent out_fire is simply consumed; a concurrent in_fire is lost.
            state  <= ST_EMPTY;
            main_q <= empty_data;
            skid_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state  <= ST_ONE;
                        main_q <= in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        // Decode stalled: park the younger entry in the skid slot.
                        state  <= ST_FULL;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        state  <= ST_EMPTY;
                        main_q <= empty_data;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state  <= ST_ONE;
                        main_q <= skid_q;
                    end
                end
                default: begin
                    state  <= ST_EMPTY;
                    main_q <= empty_data;
                    skid_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF->ID pipeline register built on a two-entry skid buffer.
//   clk, rst                          : clock, synchronous active-high reset
//   flush                             : discard all held entries
//   if_valid/if_ready/if_pc/if_inst/if_extra : fetch-side handshake and payload
//   id_valid/id_ready/id_pc/id_inst/id_extra : decode-side handshake and payload
//   stall_cnt                         : saturating count of decode-stall cycles
// All decode-side outputs come straight from registers.
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                EXTRA_W  = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT),
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [ADDR_W-1:0]  if_pc,
    input  logic [INST_W-1:0]  if_inst,
    input  logic [EXTRA_W-1:0] if_extra,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INST_W-1:0]  id_inst,
    output logic [EXTRA_W-1:0] id_extra,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int DATA_W = ADDR_W + INST_W + EXTRA_W;
    localparam logic [DATA_W-1:0] RST_DATA = {ADDR_W'(0), NOP_INST, EXTRA_W'(0)};

    logic [DATA_W-1:0] buf_out;
    logic [DATA_W-1:0] empty_data;
    skid_state_e       buf_state;
    logic              stall;

    // When the main register empties the PC is kept, the instruction becomes a
    // NOP and the sideband is cleared so decode never sees stale flags.
    assign empty_data = {id_pc, NOP_INST, EXTRA_W'(0)};

    pipe_skid_buf #(
        .DATA_W   (DATA_W),
        .RST_DATA (RST_DATA)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (if_valid),
        .in_ready   (if_ready),
        .in_data    ({if_pc, if_inst, if_extra}),
        .out_valid  (id_valid),
        .out_ready  (id_ready),
        .out_data   (buf_out),
        .empty_data (empty_data),
        .state      (buf_state)
    );

    assign {id_pc, id_inst, id_extra} = buf_out;

    assign stall = (buf_state != ST_EMPTY) & ~id_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
